// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a downstream combinational ALU from a
// valid/ready operand stream and returns its result on a valid/ready port.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           operand handshake (in_a, in_b, in_sel)
//   alu_a, alu_b, alu_sel       registered drive to the ALU
//   alu_result                  combinational ALU result
//   out_valid/out_ready         result handshake (out_result, out_sel, out_dz)
//   op_count                    completed output handshakes, wraps at 256
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    input  logic [1:0] in_sel,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [5:0] alu_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_result,
    output logic [1:0] out_sel,
    output logic       out_dz,
    output logic [7:0] op_count
);

    localparam logic [3:0] LP_RELOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [2:0] r_alu_a;
    logic [2:0] r_alu_b;
    logic [1:0] r_alu_sel;
    logic [5:0] r_out_result;
    logic [1:0] r_out_sel;
    logic       r_out_dz;
    logic [7:0] r_op_count;

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_accept;
    logic       w_handshake;
    logic       w_capture;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    // Same-edge accept skips IDLE entirely
                    w_next = in_valid ? S_EXEC : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output / strobe logic; rst_n gating keeps in_ready low during reset
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: w_in_ready = rst_n;
            S_EXEC: w_capture  = (r_cnt == 4'd0);
            S_DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = rst_n & out_ready;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
        w_accept    = w_in_ready & in_valid;
        w_handshake = w_out_valid & out_ready;
    end

    // Datapath: operand latch, settle counter, result capture, op counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 4'd0;
            r_alu_a      <= 3'd0;
            r_alu_b      <= 3'd0;
            r_alu_sel    <= 2'd0;
            r_out_result <= 6'd0;
            r_out_sel    <= 2'd0;
            r_out_dz     <= 1'b0;
            r_op_count   <= 8'd0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= in_a;
                r_alu_b   <= in_b;
                r_alu_sel <= in_sel;
                r_cnt     <= LP_RELOAD;
            end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_out_result <= alu_result;
                r_out_sel    <= r_alu_sel;
                r_out_dz     <= (r_alu_sel == 2'b11) && (r_alu_b == 3'd0);
            end
            if (w_handshake) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign out_result = r_out_result;
    assign out_sel    = r_out_sel;
    assign out_dz     = r_out_dz;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer.
// Two instances: SETTLE_CYCLES=1 and SETTLE_CYCLES=3.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n1, rst_n3;
    logic       in_valid1, in_valid3;
    logic       out_ready1, out_ready3;
    logic [2:0] in_a, in_b;
    logic [1:0] in_sel;

    logic       in_ready1, out_valid1, out_dz1;
    logic [2:0] alu_a1, alu_b1;
    logic [1:0] alu_sel1, out_sel1;
    logic [5:0] alu_res1, out_result1;
    logic [7:0] op_count1;

    logic       in_ready3, out_valid3, out_dz3;
    logic [2:0] alu_a3, alu_b3;
    logic [1:0] alu_sel3, out_sel3;
    logic [5:0] alu_res3, out_result3;
    logic [7:0] op_count3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Reference combinational ALU: 6-bit, zero-extended, div-by-0 -> 0
    function automatic logic [5:0] alu_f(input logic [2:0] a,
                                         input logic [2:0] b,
                                         input logic [1:0] s);
        case (s)
            2'b00:   return 6'(a) + 6'(b);
            2'b01:   return 6'(a) - 6'(b);
            2'b10:   return 6'(a) * 6'(b);
            default: return (b == 3'd0) ? 6'd0 : 6'(a / b);
        endcase
    endfunction

    always_comb alu_res1 = alu_f(alu_a1, alu_b1, alu_sel1);
    always_comb alu_res3 = alu_f(alu_a3, alu_b3, alu_sel3);

    alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
        .alu_result(alu_res1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1), .out_sel(out_sel1),
        .out_dz(out_dz1), .op_count(op_count1)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_result(alu_res3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_result(out_result3), .out_sel(out_sel3),
        .out_dz(out_dz3), .op_count(op_count3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n1 = 1'b0; rst_n3 = 1'b0;
        in_valid1 = 1'b0; in_valid3 = 1'b0;
        out_ready1 = 1'b0; out_ready3 = 1'b0;
        in_a = 3'd0; in_b = 3'd0; in_sel = 2'd0;
        tick(); tick();
        n_vec++;
        if ({in_ready1, out_valid1, in_ready3, out_valid3} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hs: got %b want 0000",
                     {in_ready1, out_valid1, in_ready3, out_valid3});
        end
        n_vec++;
        if ({alu_a1, alu_b1, alu_sel1, out_result1, out_sel1, out_dz1,
             op_count1} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_regs: got %h want 0",
                     {alu_a1, alu_b1, alu_sel1, out_result1, out_sel1,
                      out_dz1, op_count1});
        end
        rst_n1 = 1'b1; rst_n3 = 1'b1;
        tick();
        n_vec++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: in_ready=%b out_valid=%b want 1/0",
                     in_ready1, out_valid1);
        end
    endtask

    // One full operation on dut1 starting from IDLE
    task automatic do_op(input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] s, input logic [5:0] exp_res,
                         input logic exp_dz, input logic [7:0] exp_cnt);
        in_a = a; in_b = b; in_sel = s; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n_vec++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0 || alu_a1 !== a ||
            alu_b1 !== b || alu_sel1 !== s) begin
            n_err++;
            $display("FAIL exec: ov=%b ir=%b alu=%0d/%0d/%0d want 0/0/%0d/%0d/%0d",
                     out_valid1, in_ready1, alu_a1, alu_b1, alu_sel1, a, b, s);
        end
        tick();
        n_vec++;
        if (out_valid1 !== 1'b1 || out_result1 !== exp_res ||
            out_sel1 !== s || out_dz1 !== exp_dz) begin
            n_err++;
            $display("FAIL done: ov=%b res=%0d sel=%0d dz=%b want 1/%0d/%0d/%b",
                     out_valid1, out_result1, out_sel1, out_dz1,
                     exp_res, s, exp_dz);
        end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        n_vec++;
        if (out_valid1 !== 1'b0 || op_count1 !== exp_cnt ||
            in_ready1 !== 1'b1 || out_result1 !== exp_res) begin
            n_err++;
            $display("FAIL handshake: ov=%b cnt=%0d ir=%b res=%0d want 0/%0d/1/%0d",
                     out_valid1, op_count1, in_ready1, out_result1,
                     exp_cnt, exp_res);
        end
    endtask

    task automatic test_ops();
        do_op(3'd5, 3'd3, 2'b00, 6'b001000, 1'b0, 8'd1);
        do_op(3'd2, 3'd5, 2'b01, 6'd61, 1'b0, 8'd2);
        do_op(3'd7, 3'd7, 2'b10, 6'd49, 1'b0, 8'd3);
        do_op(3'd6, 3'd0, 2'b11, 6'd0, 1'b1, 8'd4);
        do_op(3'd6, 3'd4, 2'b11, 6'd1, 1'b0, 8'd5);
    endtask

    task automatic test_hold();
        in_a = 3'd3; in_b = 3'd2; in_sel = 2'b10; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            in_valid1 = i[0];
            in_a = 3'(i); in_b = 3'(i + 1); in_sel = 2'(i);
            tick();
            n_vec++;
            if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 ||
                out_result1 !== 6'd6 || out_sel1 !== 2'b10 ||
                alu_a1 !== 3'd3 || alu_b1 !== 3'd2 || op_count1 !== 8'd5) begin
                n_err++;
                $display("FAIL hold[%0d]: ov=%b ir=%b res=%0d a=%0d cnt=%0d want 1/0/6/3/5",
                         i, out_valid1, in_ready1, out_result1, alu_a1,
                         op_count1);
            end
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        n_vec++;
        if (op_count1 !== 8'd6 || out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: cnt=%0d ov=%b want 6/0",
                     op_count1, out_valid1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op;
        // Same-edge handshake and accept
        in_a = 3'd4; in_b = 3'd1; in_sel = 2'b01; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        in_a = 3'd3; in_b = 3'd3; in_sel = 2'b00;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        n_vec++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0 || op_count1 !== 8'd7 ||
            alu_a1 !== 3'd3 || alu_sel1 !== 2'b00 || out_result1 !== 6'd3) begin
            n_err++;
            $display("FAIL b2b_edge: ov=%b ir=%b cnt=%0d a=%0d res=%0d want 0/0/7/3/3",
                     out_valid1, in_ready1, op_count1, alu_a1, out_result1);
        end
        tick();
        n_vec++;
        if (out_valid1 !== 1'b1 || out_result1 !== 6'd6) begin
            n_err++;
            $display("FAIL b2b_result: ov=%b res=%0d want 1/6",
                     out_valid1, out_result1);
        end
        // Fresh count, then 256 streamed operations
        rst_n1 = 1'b0;
        tick();
        rst_n1 = 1'b1;
        op = 8'd0;
        in_a = op[2:0]; in_b = op[5:3]; in_sel = op[7:6];
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            logic [2:0] ea, eb;
            logic [1:0] es;
            op = 8'(i);
            ea = op[2:0]; eb = op[5:3]; es = op[7:6];
            tick();
            n_vec++;
            if (out_valid1 !== 1'b1 || out_result1 !== alu_f(ea, eb, es) ||
                out_sel1 !== es || out_dz1 !== (es == 2'b11 && eb == 3'd0)) begin
                n_err++;
                $display("FAIL stream_res[%0d]: ov=%b res=%0d sel=%0d dz=%b want 1/%0d/%0d",
                         i, out_valid1, out_result1, out_sel1, out_dz1,
                         alu_f(ea, eb, es), es);
            end
            if (i < 255) begin
                op = 8'(i + 1);
                in_a = op[2:0]; in_b = op[5:3]; in_sel = op[7:6];
            end else begin
                in_valid1 = 1'b0;
            end
            tick();
            n_vec++;
            if (op_count1 !== 8'(i + 1)) begin
                n_err++;
                $display("FAIL stream_cnt[%0d]: got %0d want %0d",
                         i, op_count1, 8'(i + 1));
            end
        end
        out_ready1 = 1'b0;
        n_vec++;
        if (op_count1 !== 8'd0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL wrap: cnt=%0d ir=%b ov=%b want 0/1/0",
                     op_count1, in_ready1, out_valid1);
        end
    endtask

    task automatic test_settle3();
        in_a = 3'd5; in_b = 3'd3; in_sel = 2'b00; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_vec++;
            if (out_valid3 !== 1'b0 || in_ready3 !== 1'b0) begin
                n_err++;
                $display("FAIL s3_wait[k+%0d]: ov=%b ir=%b want 0/0",
                         i, out_valid3, in_ready3);
            end
        end
        tick();
        n_vec++;
        if (out_valid3 !== 1'b1 || out_result3 !== 6'd8) begin
            n_err++;
            $display("FAIL s3_done: ov=%b res=%0d want 1/8",
                     out_valid3, out_result3);
        end
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        n_vec++;
        if (op_count3 !== 8'd1) begin
            n_err++;
            $display("FAIL s3_cnt: got %0d want 1", op_count3);
        end
    endtask

    task automatic test_reset_abort();
        in_a = 3'd7; in_b = 3'd7; in_sel = 2'b10; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick();
        #2;
        rst_n3 = 1'b0;
        #1;
        n_vec++;
        if ({out_valid3, in_ready3, out_dz3} !== 3'b000 ||
            {alu_a3, alu_b3, alu_sel3, out_result3, out_sel3,
             op_count3} !== 24'd0) begin
            n_err++;
            $display("FAIL abort: ov=%b ir=%b a=%0d res=%0d cnt=%0d want all 0",
                     out_valid3, in_ready3, alu_a3, out_result3, op_count3);
        end
        tick(); tick();
        rst_n3 = 1'b1;
        tick();
        in_a = 3'd6; in_b = 3'd4; in_sel = 2'b11; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if (out_valid3 !== 1'b1 || out_result3 !== 6'd1 || out_dz3 !== 1'b0 ||
            out_sel3 !== 2'b11) begin
            n_err++;
            $display("FAIL post_abort: ov=%b res=%0d dz=%b sel=%0d want 1/1/0/3",
                     out_valid3, out_result3, out_dz3, out_sel3);
        end
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        n_vec++;
        if (op_count3 !== 8'd1) begin
            n_err++;
            $display("FAIL post_abort_cnt: got %0d want 1", op_count3);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_hold();
        test_back_to_back();
        test_settle3();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
